mc_maindec: RTL and testbench

Multicycle main control FSM for the RV32I core, successor to the single-cycle `maindec`. It steps each instruction through Fetch/Decode/Execute/Memory/Writeback states and drives the datapath strobes and mux selects. Parameters add LUI/AUIPC support and an optional memory ready handshake. It sits in the multicycle controller beside `aludec` and drives the shared instruction/data memory datapath.

---
 rtl/mc_maindec.sv | 201 ++++++++++++++++++++
 tb/tb_mc_maindec.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// Multicycle main control FSM for the RV32I core: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives datapath strobes and mux selects.
module mc_maindec #(
  parameter bit EXT_EN        = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       MemReq,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] EXECUTEI = 4'd8;
  localparam logic [3:0] JAL      = 4'd9;
  localparam logic [3:0] BEQ      = 4'd10;
  localparam logic [3:0] LUI      = 4'd11;
  localparam logic [3:0] AUIPC    = 4'd12;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [3:0] state;
  logic [3:0] nextState;
  logic       ready;

  // Without the handshake every memory access completes in one cycle.
  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Next-state and Moore outputs; reset forces every output low in the same cycle.
  always_comb begin
    nextState = FETCH;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 3'b000;
    MemReq    = 1'b0;
    InstrDone = 1'b0;
    IllegalOp = 1'b0;
    State     = state;

    case (op)
      OP_STORE: ImmSrc = 3'b001;
      OP_BEQ:   ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      OP_LUI,
      OP_AUIPC: ImmSrc = EXT_EN ? 3'b100 : 3'b000;
      default:  ImmSrc = 3'b000;
    endcase

    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready;
        PCUpdate  = ready;
        nextState = ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = EXECUTER;
          OP_ITYPE:          nextState = EXECUTEI;
          OP_JAL:            nextState = JAL;
          OP_BEQ:            nextState = BEQ;
          OP_LUI: begin
            if (EXT_EN) nextState = LUI;
            else        IllegalOp = 1'b1;
          end
          OP_AUIPC: begin
            if (EXT_EN) nextState = AUIPC;
            else        IllegalOp = 1'b1;
          end
          default: IllegalOp = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nextState = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        MemReq    = 1'b1;
        AdrSrc    = 1'b1;
        nextState = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWRITE: begin
        MemReq    = 1'b1;
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = ready;
        nextState = ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b10;
        nextState = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCUpdate  = 1'b1;
        nextState = ALUWB;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        Branch    = 1'b1;
        InstrDone = 1'b1;
      end
      LUI: begin
        ALUSrcA   = 2'b11;
        ALUSrcB   = 2'b01;
        nextState = ALUWB;
      end
      AUIPC: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        nextState = ALUWB;
      end
      default: nextState = FETCH;
    endcase

    if (reset) begin
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ImmSrc    = 3'b000;
      MemReq    = 1'b0;
      InstrDone = 1'b0;
      IllegalOp = 1'b0;
      State     = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: random instruction streams with random wait states, checked cycle
// by cycle against per-instruction state sequences built from the opcode class.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemReady;
  logic [6:0] op;

  logic       pcUA, brA, rwA, mwA, irwA, adrA, mreqA, doneA, illA;
  logic [1:0] rsA, saA, sbA, aopA;
  logic [2:0] immA;
  logic [3:0] stA;
  logic       pcUB, brB, rwB, mwB, irwB, adrB, mreqB, doneB, illB;
  logic [1:0] rsB, saB, sbB, aopB;
  logic [2:0] immB;
  logic [3:0] stB;

  int nChecks = 0;
  int nErrors = 0;
  bit selB    = 1'b0;

  always #5 clk = ~clk;

  // Handshake on, extensions on
  mc_maindec #(.EXT_EN(1'b1), .MEM_HANDSHAKE(1'b1)) dutA (
    .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
    .PCUpdate(pcUA), .Branch(brA), .RegWrite(rwA), .MemWrite(mwA), .IRWrite(irwA),
    .AdrSrc(adrA), .ResultSrc(rsA), .ALUSrcA(saA), .ALUSrcB(sbA), .ALUOp(aopA),
    .ImmSrc(immA), .MemReq(mreqA), .InstrDone(doneA), .IllegalOp(illA), .State(stA));

  // Handshake off, extensions off
  mc_maindec #(.EXT_EN(1'b0), .MEM_HANDSHAKE(1'b0)) dutB (
    .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
    .PCUpdate(pcUB), .Branch(brB), .RegWrite(rwB), .MemWrite(mwB), .IRWrite(irwB),
    .AdrSrc(adrB), .ResultSrc(rsB), .ALUSrcA(saB), .ALUSrcB(sbB), .ALUOp(aopB),
    .ImmSrc(immB), .MemReq(mreqB), .InstrDone(doneB), .IllegalOp(illB), .State(stB));

  logic [23:0] obsA, obsB;
  assign obsA = {pcUA, brA, rwA, mwA, irwA, adrA, rsA, saA, sbA, aopA, immA, mreqA, doneA, illA, stA};
  assign obsB = {pcUB, brB, rwB, mwB, irwB, adrB, rsB, saB, sbB, aopB, immB, mreqB, doneB, illB, stB};

  task automatic checkVal(input string tag, input logic [23:0] got, input logic [23:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit isLegal(input logic [6:0] o, input bit ext);
    case (o)
      7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63: return 1'b1;
      7'h37, 7'h17: return ext;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] immOf(input logic [6:0] o, input bit ext);
    case (o)
      7'h23: return 3'd1;
      7'h63: return 3'd2;
      7'h6F: return 3'd3;
      7'h37, 7'h17: return ext ? 3'd4 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  // Output bundle expected in a given state, from the per-state output table
  function automatic logic [23:0] expVec(input logic [3:0] st, input bit r,
                                         input logic [6:0] o, input bit ext);
    logic pcU = 0, br = 0, rw = 0, mw = 0, irw = 0, adr = 0, mreq = 0, done = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0;
    case (st)
      4'd0:  begin mreq = 1; sb = 2; rs = 2; irw = r; pcU = r; end
      4'd1:  begin sa = 1; sb = 1; ill = !isLegal(o, ext); end
      4'd2:  begin sa = 2; sb = 1; end
      4'd3:  begin mreq = 1; adr = 1; end
      4'd4:  begin rs = 1; rw = 1; done = 1; end
      4'd5:  begin mreq = 1; adr = 1; mw = 1; done = r; end
      4'd6:  begin sa = 2; aop = 2; end
      4'd7:  begin rw = 1; done = 1; end
      4'd8:  begin sa = 2; sb = 1; aop = 2; end
      4'd9:  begin sa = 1; sb = 2; pcU = 1; end
      4'd10: begin sa = 2; aop = 1; br = 1; done = 1; end
      4'd11: begin sa = 3; sb = 1; end
      4'd12: begin sa = 1; sb = 1; end
      default: ;
    endcase
    return {pcU, br, rw, mw, irw, adr, rs, sa, sb, aop, immOf(o, ext), mreq, done, ill, st};
  endfunction

  // Runs one instruction from FETCH; rstAt selects a cycle to assert reset (-1 = none)
  task automatic runInstr(input logic [6:0] o, input int wF, input int wM, input int rstAt,
                          input bit ext, input bit hs);
    logic [3:0] sts[$];
    bit rdy[$];
    bit r;
    logic [23:0] got;
    for (int k = 0; k < (hs ? wF : 0); k++) begin sts.push_back(4'd0); rdy.push_back(1'b0); end
    sts.push_back(4'd0); rdy.push_back(1'b1);
    sts.push_back(4'd1); rdy.push_back(1'b1);
    if (isLegal(o, ext)) begin
      case (o)
        7'h03: begin
          sts.push_back(4'd2); rdy.push_back(1'b1);
          for (int k = 0; k < (hs ? wM : 0); k++) begin sts.push_back(4'd3); rdy.push_back(1'b0); end
          sts.push_back(4'd3); rdy.push_back(1'b1);
          sts.push_back(4'd4); rdy.push_back(1'b1);
        end
        7'h23: begin
          sts.push_back(4'd2); rdy.push_back(1'b1);
          for (int k = 0; k < (hs ? wM : 0); k++) begin sts.push_back(4'd5); rdy.push_back(1'b0); end
          sts.push_back(4'd5); rdy.push_back(1'b1);
        end
        7'h33: begin sts.push_back(4'd6);  sts.push_back(4'd7); rdy.push_back(1'b1); rdy.push_back(1'b1); end
        7'h13: begin sts.push_back(4'd8);  sts.push_back(4'd7); rdy.push_back(1'b1); rdy.push_back(1'b1); end
        7'h6F: begin sts.push_back(4'd9);  sts.push_back(4'd7); rdy.push_back(1'b1); rdy.push_back(1'b1); end
        7'h63: begin sts.push_back(4'd10); rdy.push_back(1'b1); end
        7'h37: begin sts.push_back(4'd11); sts.push_back(4'd7); rdy.push_back(1'b1); rdy.push_back(1'b1); end
        default: begin sts.push_back(4'd12); sts.push_back(4'd7); rdy.push_back(1'b1); rdy.push_back(1'b1); end
      endcase
    end
    op = o;
    for (int i = 0; i < sts.size(); i++) begin
      reset = (i == rstAt);
      if (hs && (sts[i] == 4'd0 || sts[i] == 4'd3 || sts[i] == 4'd5)) MemReady = rdy[i];
      else MemReady = 1'($urandom_range(0, 1));
      r = hs ? rdy[i] : 1'b1;
      @(negedge clk);
      got = selB ? obsB : obsA;
      if (reset) checkVal($sformatf("rst op=%h cyc%0d", o, i), got, 24'd0);
      else       checkVal($sformatf("op=%h cyc%0d", o, i), got, expVec(sts[i], r, o, ext));
      @(posedge clk); #1;
      if (i == rstAt) break;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    checkVal("reset", selB ? obsB : obsA, 24'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic randomRun(input int n, input bit ext, input bit hs);
    logic [6:0] ops[9];
    logic [6:0] o;
    int nLen;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63, 7'h37, 7'h17, 7'h00};
    for (int k = 0; k < n; k++) begin
      o = ops[$urandom_range(0, 8)];
      if (o == 7'h00) o = 7'($urandom);
      nLen = 7;
      runInstr(o, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, nLen - 1) : -1, ext, hs);
    end
  endtask

  initial begin
    reset = 1'b1;
    MemReady = 1'b0;
    op = 7'h00;
    @(posedge clk); #1;
    selB = 1'b0;
    doReset();
    runInstr(7'h03, 0, 0, -1, 1'b1, 1'b1);
    runInstr(7'h23, 0, 3, -1, 1'b1, 1'b1);
    runInstr(7'h33, 2, 0, -1, 1'b1, 1'b1);
    runInstr(7'h13, 0, 0, -1, 1'b1, 1'b1);
    runInstr(7'h6F, 0, 0, -1, 1'b1, 1'b1);
    runInstr(7'h63, 0, 0, -1, 1'b1, 1'b1);
    runInstr(7'h37, 0, 0, -1, 1'b1, 1'b1);
    runInstr(7'h17, 1, 0, -1, 1'b1, 1'b1);
    runInstr(7'h7F, 0, 0, -1, 1'b1, 1'b1);
    runInstr(7'h03, 0, 2, 3, 1'b1, 1'b1);
    runInstr(7'h23, 0, 2, 4, 1'b1, 1'b1);
    runInstr(7'h03, 1, 1, -1, 1'b1, 1'b1);
    randomRun(80, 1'b1, 1'b1);

    selB = 1'b1;
    doReset();
    runInstr(7'h03, 0, 0, -1, 1'b0, 1'b0);
    runInstr(7'h37, 0, 0, -1, 1'b0, 1'b0);
    runInstr(7'h17, 0, 0, -1, 1'b0, 1'b0);
    runInstr(7'h23, 0, 0, -1, 1'b0, 1'b0);
    runInstr(7'h03, 0, 0, 3, 1'b0, 1'b0);
    randomRun(60, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
